// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shadowed angle writes, one shared angle-to-ticks
// converter staged before each period boundary. Optional SERVO_SLEW_EN limits angle change per period.
module servo_pwm_multi #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int PWM_FREQ     = 50,
    parameter int NUM_CH       = 4,
    parameter int ANGLE_W      = 8,
    parameter int MAX_ANGLE    = 180,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_PULSE_US = 2000,
    parameter int SLEW_STEP    = 2,
    // one spare code so out-of-range channel numbers are representable and can be rejected
    localparam int CH_W        = $clog2(NUM_CH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [ANGLE_W-1:0] wr_angle,
    output logic               wr_err,
    output logic               clamp_flag,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic               period_start
`ifdef SERVO_SLEW_EN
    ,
    output logic [NUM_CH-1:0]  slew_busy
`endif
);

    localparam int PERIOD_TICKS = CLK_FREQ / PWM_FREQ;
    localparam int MIN_TICKS    = CLK_FREQ / 1_000_000 * MIN_PULSE_US;
    localparam int MAX_TICKS    = CLK_FREQ / 1_000_000 * MAX_PULSE_US;
    localparam int CNT_W        = $clog2(PERIOD_TICKS);
    localparam int TICK_W       = CNT_W + 1;
    localparam int PROD_W       = ANGLE_W + CNT_W;
    localparam int STAGE_BASE   = PERIOD_TICKS - 1 - NUM_CH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_TICKS - 1);

    if (MAX_TICKS >= PERIOD_TICKS || MIN_TICKS > MAX_TICKS || PERIOD_TICKS <= NUM_CH + 1 ||
        MAX_ANGLE < 1 || MAX_ANGLE >= (1 << ANGLE_W) || NUM_CH < 1 || NUM_CH > 16) begin : g_bad_cfg
        $error("servo_pwm_multi: invalid parameter combination");
    end

    function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
        return (a > ANGLE_W'(MAX_ANGLE)) ? ANGLE_W'(MAX_ANGLE) : a;
    endfunction

    function automatic logic [TICK_W-1:0] sat_ticks(input logic [PROD_W:0] t);
        return (t >= (PROD_W+1)'(PERIOD_TICKS)) ? TICK_W'(PERIOD_TICKS) : TICK_W'(t);
    endfunction

    function automatic logic [TICK_W-1:0] angle_to_ticks(input logic [ANGLE_W-1:0] a);
        logic [PROD_W-1:0] prod;
        logic [PROD_W:0]   sum;
        prod = PROD_W'(a) * PROD_W'(MAX_TICKS - MIN_TICKS);
        prod = prod / PROD_W'(MAX_ANGLE);
        sum  = {1'b0, prod} + (PROD_W+1)'(MIN_TICKS);
        return sat_ticks(sum);
    endfunction

`ifdef SERVO_SLEW_EN
    function automatic logic [ANGLE_W-1:0] slew_toward(input logic [ANGLE_W-1:0] cur,
                                                       input logic [ANGLE_W-1:0] tgt);
        if (tgt > cur)
            return (tgt - cur > ANGLE_W'(SLEW_STEP)) ? cur + ANGLE_W'(SLEW_STEP) : tgt;
        else
            return (cur - tgt > ANGLE_W'(SLEW_STEP)) ? cur - ANGLE_W'(SLEW_STEP) : tgt;
    endfunction

    logic [ANGLE_W-1:0] cur_q [NUM_CH];
`endif

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ANGLE_W-1:0] shadow_q [NUM_CH];
    logic [TICK_W-1:0]  pend_q   [NUM_CH];
    logic [TICK_W-1:0]  active_q [NUM_CH];
    logic [NUM_CH-1:0]  act_en_q, pwm_q;
    logic               ps_q, wr_err_q, clamp_q;

    logic               wr_ok, commit;
    logic [ANGLE_W-1:0] wr_ang_c;
    logic [ANGLE_W-1:0] tgt_d   [NUM_CH];
    logic [ANGLE_W-1:0] nxt_ang [NUM_CH];
    logic [NUM_CH-1:0]  byp_sel, stg_oh, after_slot;
    logic [ANGLE_W-1:0] byp_ang, stg_ang;
    logic [TICK_W-1:0]  byp_ticks, stg_ticks;
    logic [TICK_W-1:0]  commit_ticks [NUM_CH];

    assign wr_ok    = wr_en && (wr_ch < CH_W'(NUM_CH));
    assign wr_ang_c = clamp_angle(wr_angle);
    assign commit   = en && (cnt_q == LAST);

    // nxt_ang is the angle the coming commit drives each channel to, including this cycle's write
    always_comb begin
        cnt_d   = '0;
        byp_ang = '0;
        stg_ang = '0;
        if (en && cnt_q != LAST)
            cnt_d = cnt_q + CNT_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
            byp_sel[i]    = wr_ok && (wr_ch == CH_W'(i));
            stg_oh[i]     = (cnt_q == CNT_W'(STAGE_BASE + i));
            after_slot[i] = (cnt_q > CNT_W'(STAGE_BASE + i));
            tgt_d[i]      = byp_sel[i] ? wr_ang_c : shadow_q[i];
`ifdef SERVO_SLEW_EN
            nxt_ang[i]    = slew_toward(cur_q[i], tgt_d[i]);
`else
            nxt_ang[i]    = tgt_d[i];
`endif
            if (byp_sel[i])
                byp_ang = nxt_ang[i];
            if (stg_oh[i])
                stg_ang = nxt_ang[i];
        end
    end

    // One converter walks the channels in the staging window; the other serves late writes.
    assign stg_ticks = angle_to_ticks(stg_ang);
    assign byp_ticks = angle_to_ticks(byp_ang);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            commit_ticks[i] = byp_sel[i] ? byp_ticks : pend_q[i];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (byp_sel[i] && after_slot[i])
                pend_q[i] <= byp_ticks;
            else if (stg_oh[i])
                pend_q[i] <= stg_ticks;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            ps_q     <= 1'b0;
            wr_err_q <= 1'b0;
            clamp_q  <= 1'b0;
            pwm_q    <= '0;
            act_en_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= TICK_W'(MIN_TICKS);
`ifdef SERVO_SLEW_EN
                cur_q[i]    <= '0;
`endif
            end
        end else begin
            cnt_q    <= cnt_d;
            ps_q     <= (cnt_d == LAST);
            wr_err_q <= wr_en && !wr_ok;
            clamp_q  <= wr_ok && (wr_angle > ANGLE_W'(MAX_ANGLE));
            if (commit)
                act_en_q <= ch_en;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= tgt_d[i];
                if (commit) begin
                    active_q[i] <= commit_ticks[i];
`ifdef SERVO_SLEW_EN
                    cur_q[i]    <= nxt_ang[i];
`endif
                end
                pwm_q[i] <= en && act_en_q[i] && ({1'b0, cnt_q} < active_q[i]);
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign wr_err       = wr_err_q;
    assign clamp_flag   = clamp_q;

`ifdef SERVO_SLEW_EN
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            slew_busy[i] = (cur_q[i] != shadow_q[i]);
    end
`endif

endmodule
